dbus_wait_responder: RTL and testbench
======================================

// Module: dbus_wait_responder
// PURPOSE
// - Data-bus peripheral responder: the target end of the dbus request/response protocol the LSU/dcache side initiates.
// - Word-addressed scratch RAM with a programmable wait-state counter; returns a single-cycle ack with read data.
// - Sits beside bmem on the dbus as a second decoded slave, selected by its own sel_i.
// - Gives the store-buffer path a slow, back-pressuring target so drain and stall behaviour can be exercised.
// PARAMETERS
// - DATA_W       32   data width; byte enables are DATA_W/8 wide.
// - ADDR_W       32   dbus byte-address width.
// - DEPTH        64   number of DATA_W words; power of two.
// - WAIT_CYCLES  2    cycles spent in WAIT before ack; 0 allowed.
// PORTS
// - clk          in   1          system clock, rising edge.
// - rst_n        in   1          asynchronous active-low reset.
// - sel_i        in   1          address-decode select for this slave.
// - req_i        in   1          request valid; held by the initiator until ack_o is seen.
// - we_i         in   1          1 = write, 0 = read.
// - addr_i       in   ADDR_W     byte address; word index = addr_i[$clog2(DEPTH)+1:2].
// - wdata_i      in   DATA_W     write data.
// - be_i         in   DATA_W/8   byte enables, write only.
// - flush_i      in   1          abort of the in-flight request (LSU flush).
// - rdata_o      out  DATA_W     read data; valid only while ack_o=1, else 0.
// - ack_o        out  1          one-cycle completion pulse.
// - err_o        out  1          error qualifier, valid with ack_o.
// - busy_o       out  1          1 in WAIT or RESP.
// BEHAVIOUR
// - Reset (async): state=IDLE; rdata_o, ack_o, err_o and busy_o = 0; wait counter = 0; all RAM words cleared to 0.
// - FSM states: IDLE -> WAIT -> RESP -> IDLE.
// - IDLE: if req_i && sel_i at a rising edge:
//   - latch we, addr, wdata and be.
//   - go to WAIT with counter = WAIT_CYCLES, or go straight to RESP when WAIT_CYCLES = 0.
//   - req_i without sel_i is ignored.
// - WAIT: counter decrements each cycle; at 1, go to RESP.
//   - Latency from accept edge to ack_o high = WAIT_CYCLES + 1 cycles.
//   - Inputs other than flush_i are ignored in WAIT; latched values are used.
// - RESP: ack_o = 1 for exactly one cycle; busy_o = 1.
//   - Write: RAM[idx] updated per byte (be_i[k] selects byte k) at the edge leaving RESP.
//   - Read: rdata_o = RAM[idx] during RESP.
//   - Next state is always IDLE.
// - Back-to-back requests: the initiator deasserts req_i in the cycle after it samples ack_o.
//   - req_i still high in the IDLE cycle after RESP is accepted as a new request (min 1 idle cycle between acks).
// - flush_i:
//   - In WAIT: return to IDLE next edge; no ack, no write, counter cleared.
//   - In RESP: ignored; the write commits and ack is issued.
//   - In IDLE with req_i: the request is not accepted.
// - Read-after-write to the same word: the second request observes the new data (the write commits before the next accept).
// - be_i = 0 on a write: acked normally, RAM unchanged.
// - Reset asserted mid-transaction: immediate return to IDLE; no ack; RAM cleared.
// CONFIGURATION
// - Macro DBUS_RESP_ERR_EN.
// - Defined: a request is flagged as an error if addr_i[1:0] != 0 or the word index is >= DEPTH (upper address bits nonzero).
//   - The error is flagged at accept time; the request goes through WAIT normally.
//   - In RESP: ack_o = 1, err_o = 1, rdata_o = 0, no RAM write.
// - Undefined: err_o tied 0; addr_i[1:0] ignored; upper bits ignored (index wraps modulo DEPTH).
// TESTING
// - Reset, then write 0xDEADBEEF to addr 0x10 with be = 4'hF and WAIT_CYCLES = 2 -> ack_o high exactly 3 cycles after accept; err_o = 0.
// - Read addr 0x10 -> ack_o with rdata_o = 0xDEADBEEF; rdata_o = 0 in the cycles before and after the ack.
// - Write 0x000000AA to 0x10 with be = 4'h1, then read 0x10 -> 0xDEADBEAA.
// - Write to 0x14, then assert flush_i during WAIT -> no ack; a following read of 0x14 returns 0x00000000.
// - Hold req_i high with sel_i = 1 for 3 reads -> 3 acks, each separated by >= 1 idle cycle; busy_o = 0 only in IDLE.
// - With DBUS_RESP_ERR_EN defined, read 0x13 -> ack = 1, err = 1, rdata = 0.
//   - Undefined: write to 0x100 (DEPTH = 64) aliases to 0x000.

Source files
------------

// File: rtl/dbus_wait_responder.sv
// ============================================================================
// dbus_wait_responder
//
// Target-side responder for the dbus request/response protocol. It provides a
// word-addressed scratch RAM behind a programmable number of wait states. It
// sits beside bmem as a second decoded slave, so the store-buffer path has a
// slow, back-pressuring target. Each accepted request completes with a
// one-cycle ack_o pulse. Read data is driven only while ack_o is high.
//
// Sequence per request: IDLE -(accept)-> WAIT x WAIT_CYCLES -> RESP -> IDLE.
// When WAIT_CYCLES = 0 the WAIT state is skipped. The ack therefore appears
// in the (WAIT_CYCLES+1)-th cycle after the accepting clock edge.
//
// Optional feature (compile-time macro DBUS_RESP_ERR_EN):
//   When defined, a request is marked as an error when it is misaligned
//   (addr_i[1:0] != 0) or when it lies outside the RAM (any address bit above
//   the word index is set). An erroring request still runs through WAIT. It is
//   then acked with err_o = 1 and rdata_o = 0, and it does not write the RAM.
//   When undefined, err_o is tied low and the word index wraps modulo DEPTH.
//
// Parameters:
//   DATA_W       data width; byte enables are DATA_W/8 wide
//   ADDR_W       dbus byte-address width
//   DEPTH        number of DATA_W words (power of two)
//   WAIT_CYCLES  wait states between accept and response (0 allowed)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset (also clears the RAM)
//   sel_i    in   address-decode select for this slave
//   req_i    in   request valid; held by the initiator until ack_o is seen
//   we_i     in   1 = write, 0 = read
//   addr_i   in   byte address; word index = addr_i[$clog2(DEPTH)+1:2]
//   wdata_i  in   write data
//   be_i     in   byte enables (writes only)
//   flush_i  in   aborts a request that is still waiting
//   rdata_o  out  read data, valid only with ack_o, otherwise 0
//   ack_o    out  one-cycle completion pulse
//   err_o    out  error qualifier, valid with ack_o
//   busy_o   out  high in WAIT or RESP
// ============================================================================
module dbus_wait_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sel_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic                  flush_i,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    // Request captured at the accept edge (stage 1 of the transaction).
    logic               we_p1;
    logic               err_p1;
    logic [IDX_W-1:0]   idx_p1;
    logic [DATA_W-1:0]  wdata_p1;
    logic [BE_W-1:0]    be_p1;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               accept;
    logic               commit_wr;
    logic               req_err;
    logic [IDX_W-1:0]   req_idx;

    // Merges new bytes into an old word, one enable per byte lane.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int k = 0; k < BE_W; k++) begin
            mask[8*k +: 8] = {8{be[k]}};
        end
        return (old_word & ~mask) | (new_word & mask);
    endfunction

    assign req_idx = addr_i[IDX_W+1:2];

`ifdef DBUS_RESP_ERR_EN
    // Misaligned, or beyond the RAM: any address bit above the index is set.
    assign req_err = (addr_i[1:0] != 2'b00) || (addr_i[ADDR_W-1:IDX_W+2] != '0);
`else
    // The index wraps modulo DEPTH and the byte offset is ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[ADDR_W-1:IDX_W+2], addr_i[1:0]};
    assign req_err          = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit_wr = 1'b0;
        ack_o     = 1'b0;
        err_o     = 1'b0;
        busy_o    = 1'b0;
        rdata_o   = '0;

        case (state)
            S_IDLE: begin
                // A flush in the same cycle as a request prevents the accept.
                if (req_i && sel_i && !flush_i) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end

            S_WAIT: begin
                busy_o = 1'b1;
                if (flush_i) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt <= CNT_W'(1)) begin
                    state_nxt = S_RESP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            S_RESP: begin
                // A flush is too late here: the response always completes.
                busy_o    = 1'b1;
                ack_o     = 1'b1;
                err_o     = err_p1;
                state_nxt = S_IDLE;
                if (!err_p1) begin
                    if (we_p1) begin
                        commit_wr = 1'b1;
                    end else begin
                        rdata_o = mem[idx_p1];
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and request capture (control)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            we_p1  <= 1'b0;
            err_p1 <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                we_p1  <= we_i;
                err_p1 <= req_err;
            end
        end
    end

    // Request data capture; only meaningful after an accept, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_p1   <= req_idx;
            wdata_p1 <= wdata_i;
            be_p1    <= be_i;
        end
    end

    // ------------------------------------------------------------------
    // Scratch RAM: cleared by reset; a write commits on the edge leaving
    // RESP, so a read accepted afterwards sees the new data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit_wr) begin
            mem[idx_p1] <= merge_bytes(mem[idx_p1], wdata_p1, be_p1);
        end
    end

endmodule

// File: tb/tb_dbus_wait_responder.sv
module tb_dbus_wait_responder;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int DEPTH       = 64;
    localparam int WAIT_CYCLES = 2;
    localparam int LAT         = WAIT_CYCLES + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel, req, we, flush;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack, err, busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    dbus_wait_responder #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel_i   (sel),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .be_i    (be),
        .flush_i (flush),
        .rdata_o (rdata),
        .ack_o   (ack),
        .err_o   (err),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model helpers ----------------
    function automatic int widx(input logic [31:0] a);
        return int'((a / 32'd4) % 32'(DEPTH));
    endfunction

    function automatic logic addr_err(input logic [31:0] a);
`ifdef DBUS_RESP_ERR_EN
        return ((a % 32'd4) != 32'd0) || ((a / 32'd4) >= 32'(DEPTH));
`else
        return (a === 32'hxxxx_xxxx);
`endif
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] b);
        logic [31:0] m;
        m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (old & ~m) | (nw & m);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] e, input logic ee);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.be = b; v.exp_rd = e; v.exp_err = ee;
        tbl.push_back(v);
    endtask

    // One full protocol transaction. It is entered while the DUT is idle and
    // before the accepting edge, and it leaves at the negedge of the idle
    // cycle that follows the ack.
    task automatic txn(input string nm, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic [31:0] exp_rd, input logic exp_err);
        sel = 1'b1; req = 1'b1; we = w; addr = a; wdata = d; be = b;
        tick();
        for (int c = 1; c <= LAT; c++) begin
            if (c < LAT) begin
                we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
            end else begin
                we = w; addr = a; wdata = d; be = b;
            end
            @(negedge clk);
            chk({nm, ".ack"}, 32'(ack), 32'(c == LAT));
            chk({nm, ".busy"}, 32'(busy), 32'd1);
            chk({nm, ".rdata"}, rdata, (c == LAT && !w && !exp_err) ? exp_rd : 32'd0);
            if (c == LAT) chk({nm, ".err"}, 32'(err), 32'(exp_err));
            tick();
        end
        req = 1'b0; sel = 1'b0;
        @(negedge clk);
        chk({nm, ".idle_ack"}, 32'(ack), 32'd0);
        chk({nm, ".idle_busy"}, 32'(busy), 32'd0);
        chk({nm, ".idle_rdata"}, rdata, 32'd0);
        if (w && !exp_err) model_mem[widx(a)] = merge(model_mem[widx(a)], d, b);
    endtask

    initial begin
        int          gap;
        int          ph;
        logic        rw;
        logic [31:0] ra, rd;
        logic [3:0]  rb;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        rst_n = 1'b0; sel = 1'b0; req = 1'b0; we = 1'b0; flush = 1'b0;
        addr = 32'd0; wdata = 32'd0; be = 4'd0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst.ack", 32'(ack), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        rst_n = 1'b1;

        // ---------------- directed table ----------------
        add(1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
        add(1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
        add(1'b1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        1'b0);
        add(1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0);
        add(1'b1, 32'h18,  32'h12345678, 4'h0, 32'h0,        1'b0);
        add(1'b0, 32'h18,  32'h0,        4'h0, 32'h00000000, 1'b0);
`ifdef DBUS_RESP_ERR_EN
        add(1'b0, 32'h13,  32'h0,        4'h0, 32'h0,        1'b1);
        add(1'b1, 32'h12,  32'h0,        4'hF, 32'h0,        1'b1);
        add(1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1);
        add(1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0);
        add(1'b0, 32'h0,   32'h0,        4'h0, 32'h00000000, 1'b0);
`else
        add(1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0);
        add(1'b0, 32'h000, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0);
        add(1'b0, 32'h103, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0);
        add(1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0);
`endif
        foreach (tbl[i]) begin
            txn($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata,
                tbl[i].be, tbl[i].exp_rd, tbl[i].exp_err);
        end

        // ---------------- flush during WAIT ----------------
        sel = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h14; wdata = 32'h55AA55AA; be = 4'hF;
        tick();
        flush = 1'b1; req = 1'b0; sel = 1'b0;
        @(negedge clk);
        chk("flush.wait_busy", 32'(busy), 32'd1);
        chk("flush.wait_ack", 32'(ack), 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush.idle_busy", 32'(busy), 32'd0);
        chk("flush.idle_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush.no_ack", 32'(ack), 32'd0);
        end
        txn("flush.read14", 1'b0, 32'h14, 32'h0, 4'h0, 32'h00000000, 1'b0);

        // ------------- flush in IDLE, req without sel -------------
        sel = 1'b1; req = 1'b1; flush = 1'b1; we = 1'b1;
        addr = 32'h14; wdata = 32'hFFFFFFFF; be = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idleflush.busy", 32'(busy), 32'd0);
            chk("idleflush.ack", 32'(ack), 32'd0);
        end
        flush = 1'b0; sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nosel.busy", 32'(busy), 32'd0);
        end
        req = 1'b0;
        txn("nosel.read14", 1'b0, 32'h14, 32'h0, 4'h0, 32'h00000000, 1'b0);

        // ---------------- req held high for three reads ----------------
        tick();
        sel = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h10; wdata = 32'd0; be = 4'd0;
        for (int c = 1; c <= 3 * (LAT + 1) - 1; c++) begin
            tick();
            @(negedge clk);
            ph = c % (LAT + 1);
            chk($sformatf("hold.c%0d.ack", c), 32'(ack), 32'(ph == LAT));
            chk($sformatf("hold.c%0d.busy", c), 32'(busy), 32'(ph != 0));
            chk($sformatf("hold.c%0d.rdata", c), rdata,
                (ph == LAT) ? model_mem[widx(32'h10)] : 32'd0);
        end
        tick();
        req = 1'b0; sel = 1'b0;
        @(negedge clk);
        chk("hold.end_busy", 32'(busy), 32'd0);
        chk("hold.end_ack", 32'(ack), 32'd0);

        // ---------------- reset mid-transaction ----------------
        sel = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h11112222; be = 4'hF;
        tick();
        @(negedge clk);
        chk("midrst.busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.ack", 32'(ack), 32'd0);
        req = 1'b0; sel = 1'b0; we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        txn("midrst.read10", 1'b0, 32'h10, 32'h0, 4'h0, 32'h00000000, 1'b0);
        txn("midrst.read20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h00000000, 1'b0);

        // ---------------- randomized traffic vs model ----------------
        for (int n = 0; n < 60; n++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                flush = 1'($urandom);
                sel   = flush ? 1'($urandom) : 1'b0;
                req   = 1'($urandom);
                @(negedge clk);
                chk($sformatf("rnd%0d.gap_busy", n), 32'(busy), 32'd0);
            end
            req = 1'b0; sel = 1'b0; flush = 1'b0;
            rw = 1'($urandom);
`ifdef DBUS_RESP_ERR_EN
            ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
`else
            ra = $urandom;
`endif
            rd = $urandom;
            rb = 4'($urandom);
            txn($sformatf("rnd%0d", n), rw, ra, rd, rb, model_mem[widx(ra)], addr_err(ra));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
